// File: rtl/cla_addsub_pipe.sv
// Pipelined add/subtract unit: 4-bit carry-lookahead groups joined by a
// parallel-prefix group lookahead, followed by STAGES valid/ready register stages.
module cla_addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic [1:0]       op,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic [3:0]       flags
);

  localparam int NG = WIDTH / 4;

  logic [WIDTH-1:0] bx;
  logic             cx;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [NG-1:0]    grp_p;
  logic [NG-1:0]    grp_g;
  logic [NG-1:0]    grp_cin;
  logic             cout;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] res;
  logic [3:0]       res_flags;

  logic [STAGES-1:0] vld;
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [3:0]        flg_q [STAGES];
  logic              adv;
  logic              take;

  // op[0] selects inversion of b; op[1] selects the external carry-in.
  always_comb begin
    bx = op[0] ? ~b : b;
    cx = op[1] ? c_in : op[0];
    p  = a | bx;
    g  = a & bx;
  end

  always_comb begin
    grp_p = '0;
    grp_g = '0;
    for (int k = 0; k < NG; k++) begin
      grp_p[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
      grp_g[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end
  end

  // Carry-in is folded into group 0, so each prefix G is directly the group carry-out.
  always_comb begin : group_lookahead
    logic [NG-1:0] lg;
    logic [NG-1:0] lp;
    logic [NG-1:0] og;
    logic [NG-1:0] opp;
    lg    = grp_g;
    lp    = grp_p;
    lg[0] = grp_g[0] | (grp_p[0] & cx);
    og    = lg;
    opp   = lp;
    for (int d = 1; d < NG; d = d * 2) begin
      og  = lg;
      opp = lp;
      for (int k = d; k < NG; k++) begin
        lg[k] = og[k] | (opp[k] & og[k-d]);
        lp[k] = opp[k] & opp[k-d];
      end
    end
    grp_cin[0] = cx;
    for (int k = 1; k < NG; k++) begin
      grp_cin[k] = lg[k-1];
    end
    cout = lg[NG-1];
  end

  always_comb begin
    carry = '0;
    for (int k = 0; k < NG; k++) begin
      carry[4*k]   = grp_cin[k];
      carry[4*k+1] = g[4*k] | (p[4*k] & grp_cin[k]);
      carry[4*k+2] = g[4*k+1]
                   | (p[4*k+1] & g[4*k])
                   | (p[4*k+1] & p[4*k] & grp_cin[k]);
      carry[4*k+3] = g[4*k+2]
                   | (p[4*k+2] & g[4*k+1])
                   | (p[4*k+2] & p[4*k+1] & g[4*k])
                   | (p[4*k+2] & p[4*k+1] & p[4*k] & grp_cin[k]);
    end
    res       = a ^ bx ^ carry;
    res_flags = {res[WIDTH-1],
                 ~|res,
                 cout,
                 (a[WIDTH-1] == bx[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1])};
  end

  assign adv       = !vld[STAGES-1] || out_ready;
  assign in_ready  = adv;
  assign take      = in_valid && adv;
  assign out_valid = vld[STAGES-1];
  assign sum       = sum_q[STAGES-1];
  assign flags     = flg_q[STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
    end else if (flush) begin
      vld <= '0;
    end else if (adv) begin
      vld[0] <= take;
      for (int i = 1; i < STAGES; i++) begin
        vld[i] <= vld[i-1];
      end
    end
  end

  // Data only moves with adv, which keeps a stalled result stable at the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        sum_q[i] <= '0;
        flg_q[i] <= '0;
      end
    end else if (adv) begin
      sum_q[0] <= res;
      flg_q[0] <= res_flags;
      for (int i = 1; i < STAGES; i++) begin
        sum_q[i] <= sum_q[i-1];
        flg_q[i] <= flg_q[i-1];
      end
    end
  end

endmodule
